register_file_mp: RTL and testbench

Parametrised multi-port register file for the processor datapath: configurable data width, depth and read-port count, two write ports with defined collision priority, optional hardwired zero register, and a hardware clear sequencer that zeroes every entry after reset. It sits between decode (read addresses) and write-back (write ports), replacing the fixed 32x32 two-read/one-write file with a block that also serves wider or deeper configurations.

---
 rtl/register_file_mp.sv | 174 +++++++++++++++++
 tb/tb_register_file_mp.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// register_file_mp
//
// Multi-port register file for the processor datapath. It has two write
// ports, NUM_RD asynchronous read ports, an optional hardwired zero entry,
// and a clear sequencer. After reset the sequencer zeroes every entry, one
// entry per clock, before the file accepts writes.
//
// Parameters
//   DATA_W   : width of each entry (default 32)
//   ADDR_W   : address width; DEPTH = 2**ADDR_W (default 5)
//   NUM_RD   : number of combinational read ports, 1..4 (default 2)
//   ZERO_REG : 1 = entry 0 always reads as zero and ignores writes (default 1)
//
// Optional feature macro
//   REGFILE_BYPASS_EN : when defined, a read in READY whose address matches an
//                       enabled write address in the same cycle returns the
//                       incoming write data. Port B has priority. The bypass
//                       never applies to entry 0 when ZERO_REG=1, and never
//                       applies during CLEAR.
//
// Ports
//   CLK  : clock; all state changes on the rising edge
//   RST  : synchronous, active-high reset; starts the clear sequence
//   WE3, A3, WD3 : write port A (enable, address, data)
//   WE4, A4, WD4 : write port B (enable, address, data); port B wins when
//                  both ports write the same address
//   A_RD : packed read addresses; port i is at [i*ADDR_W +: ADDR_W]
//   RD   : packed read data;      port i is at [i*DATA_W +: DATA_W]
//   BUSY : high while the clear sequencer runs; writes are ignored and every
//          RD port drives 0
//
// Write ports have no handshake. A write enable is honoured only when BUSY is
// low. BUSY is the producer's back-pressure: a request made while BUSY is
// high is dropped and is not queued.
//
// Controller state is kept in one packed struct (ctl_q: state + clear
// counter). This gives a checker one place to bind to.

module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       WE3,
    input  logic [ADDR_W-1:0]          A3,
    input  logic [DATA_W-1:0]          WD3,
    input  logic                       WE4,
    input  logic [ADDR_W-1:0]          A4,
    input  logic [DATA_W-1:0]          WD4,
    input  logic [NUM_RD*ADDR_W-1:0]   A_RD,
    output logic [NUM_RD*DATA_W-1:0]   RD,
    output logic                       BUSY
);

    localparam int DEPTH    = 2 ** ADDR_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    typedef struct packed {
        state_t              state;
        logic [ADDR_W-1:0]   clr_cnt;
    } ctl_t;

    ctl_t ctl_q;
    ctl_t ctl_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic in_clear;
    logic in_ready;
    logic wr_a;
    logic wr_b;

    assign in_clear = (ctl_q.state == CLEAR);
    assign in_ready = (ctl_q.state == READY);

    // Writes to entry 0 are dropped here. Entry 0 then keeps the zero that
    // the clear sequence wrote into it.
    assign wr_a = WE3 && in_ready && !(HAS_ZERO && (A3 == '0));
    assign wr_b = WE4 && in_ready && !(HAS_ZERO && (A4 == '0));

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctl_q <= '{state: CLEAR, clr_cnt: '0};
        end else begin
            ctl_q <= ctl_d;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state
    // The clear counter walks 0..DEPTH-1. The edge that clears the last
    // entry (counter all ones) hands over to READY.
    // ------------------------------------------------------------------
    always_comb begin
        ctl_d = ctl_q;
        if (ctl_q.state == CLEAR) begin
            ctl_d.clr_cnt = ctl_q.clr_cnt + ADDR_W'(1);
            if (&ctl_q.clr_cnt) begin
                ctl_d.state   = READY;
                ctl_d.clr_cnt = '0;
            end
        end
    end

    // BUSY comes straight from the state flop, with no input-to-output path.
    assign BUSY = in_clear;

    // ------------------------------------------------------------------
    // Storage
    // While RST is held, entry 0 is zeroed on every edge; the counter is
    // pinned at 0 at the same time. In CLEAR the counter selects which
    // entry to zero. In READY, port B's assignment comes last, so it wins
    // an address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem[0] <= '0;
        end else if (in_clear) begin
            mem[ctl_q.clr_cnt] <= '0;
        end else begin
            if (wr_a) begin
                mem[A3] <= WD3;
            end
            if (wr_b) begin
                mem[A4] <= WD4;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports (combinational)
    // Priority from lowest to highest: stored value, bypass (if built in),
    // zero-register mask, CLEAR mask.
    // ------------------------------------------------------------------
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        ra = '0;
        rv = '0;
        RD = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = A_RD[i*ADDR_W +: ADDR_W];
            rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
            // wr_a/wr_b already exclude CLEAR and entry 0 (when hardwired).
            if (wr_a && (A3 == ra)) begin
                rv = WD3;
            end
            if (wr_b && (A4 == ra)) begin
                rv = WD4;
            end
`endif
            if (HAS_ZERO && (ra == '0)) begin
                rv = '0;
            end
            if (in_clear) begin
                rv = '0;
            end
            RD[i*DATA_W +: DATA_W] = rv;
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Testbench for register_file_mp.
// Two instances share the clock and reset: the default 32x32 2-read file
// and a 64-bit, 64-entry, 3-read file. Each instance has its own reference
// model. The model is a plain array plus a clear position and a busy flag,
// updated once per rising edge from the specified rules.

module tb_register_file_mp;

    localparam int N_DW = 32, N_AW = 5, N_RD = 2, N_DEPTH = 32;
    localparam int W_DW = 64, W_AW = 6, W_RD = 3, W_DEPTH = 64;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // ---------------- narrow instance ----------------
    logic                    n_we3, n_we4;
    logic [N_AW-1:0]         n_a3, n_a4;
    logic [N_DW-1:0]         n_wd3, n_wd4;
    logic [N_RD*N_AW-1:0]    n_ard;
    logic [N_RD*N_DW-1:0]    n_rd;
    logic                    n_busy;

    register_file_mp u_narrow (
        .CLK(CLK), .RST(RST),
        .WE3(n_we3), .A3(n_a3), .WD3(n_wd3),
        .WE4(n_we4), .A4(n_a4), .WD4(n_wd4),
        .A_RD(n_ard), .RD(n_rd), .BUSY(n_busy)
    );

    // ---------------- wide instance ----------------
    logic                    w_we3, w_we4;
    logic [W_AW-1:0]         w_a3, w_a4;
    logic [W_DW-1:0]         w_wd3, w_wd4;
    logic [W_RD*W_AW-1:0]    w_ard;
    logic [W_RD*W_DW-1:0]    w_rd;
    logic                    w_busy;

    register_file_mp #(
        .DATA_W(64), .ADDR_W(6), .NUM_RD(3), .ZERO_REG(1)
    ) u_wide (
        .CLK(CLK), .RST(RST),
        .WE3(w_we3), .A3(w_a3), .WD3(w_wd3),
        .WE4(w_we4), .A4(w_a4), .WD4(w_wd4),
        .A_RD(w_ard), .RD(w_rd), .BUSY(w_busy)
    );

    // ---------------- reference model ----------------
    logic [63:0] n_mem [N_DEPTH];
    logic [63:0] w_mem [W_DEPTH];
    int          n_pos = 0, w_pos = 0;
    bit          n_busy_m = 1'b1, w_busy_m = 1'b1;
    bit          known = 1'b0;

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected value of a read in the current cycle, given the write-port
    // inputs present right now.
    function automatic logic [63:0] n_expect(input int addr);
        logic [63:0] v;
        if (n_busy_m || addr == 0) return 64'd0;
        v = n_mem[addr];
`ifdef REGFILE_BYPASS_EN
        if (n_we3 && int'(n_a3) == addr) v = 64'(n_wd3);
        if (n_we4 && int'(n_a4) == addr) v = 64'(n_wd4);
`endif
        return v;
    endfunction

    function automatic logic [63:0] w_expect(input int addr);
        logic [63:0] v;
        if (w_busy_m || addr == 0) return 64'd0;
        v = w_mem[addr];
`ifdef REGFILE_BYPASS_EN
        if (w_we3 && int'(w_a3) == addr) v = w_wd3;
        if (w_we4 && int'(w_a4) == addr) v = w_wd4;
`endif
        return v;
    endfunction

    // Model update for one rising edge.
    task automatic model_edge();
        if (RST) begin
            n_busy_m = 1'b1; n_pos = 0; n_mem[0] = 64'd0;
            w_busy_m = 1'b1; w_pos = 0; w_mem[0] = 64'd0;
        end else begin
            if (n_busy_m) begin
                n_mem[n_pos] = 64'd0;
                n_pos++;
                if (n_pos == N_DEPTH) begin n_busy_m = 1'b0; n_pos = 0; end
            end else begin
                if (n_we3 && n_a3 != 0) n_mem[n_a3] = 64'(n_wd3);
                if (n_we4 && n_a4 != 0) n_mem[n_a4] = 64'(n_wd4);
            end
            if (w_busy_m) begin
                w_mem[w_pos] = 64'd0;
                w_pos++;
                if (w_pos == W_DEPTH) begin w_busy_m = 1'b0; w_pos = 0; end
            end else begin
                if (w_we3 && w_a3 != 0) w_mem[w_a3] = w_wd3;
                if (w_we4 && w_a4 != 0) w_mem[w_a4] = w_wd4;
            end
        end
    endtask

    // One clock: check outputs at the falling edge (pre-edge state with the
    // current inputs), then apply the rising edge to the model.
    task automatic step();
        @(negedge CLK);
        if (known) begin
            check("n_busy", 64'(n_busy), 64'(n_busy_m));
            check("w_busy", 64'(w_busy), 64'(w_busy_m));
            for (int i = 0; i < N_RD; i++) exp_q.push_back(n_expect(int'(n_ard[i*N_AW +: N_AW])));
            for (int i = 0; i < N_RD; i++)
                check($sformatf("n_rd%0d@%0d", i, n_ard[i*N_AW +: N_AW]),
                      64'(n_rd[i*N_DW +: N_DW]), exp_q.pop_front());
            for (int i = 0; i < W_RD; i++) exp_q.push_back(w_expect(int'(w_ard[i*W_AW +: W_AW])));
            for (int i = 0; i < W_RD; i++)
                check($sformatf("w_rd%0d@%0d", i, w_ard[i*W_AW +: W_AW]),
                      w_rd[i*W_DW +: W_DW], exp_q.pop_front());
        end
        @(posedge CLK);
        model_edge();
        if (RST) known = 1'b1;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic n_set(input bit we3, input int a3, input logic [31:0] wd3,
                         input bit we4, input int a4, input logic [31:0] wd4,
                         input int r0, input int r1);
        n_we3 = we3; n_a3 = N_AW'(a3); n_wd3 = wd3;
        n_we4 = we4; n_a4 = N_AW'(a4); n_wd4 = wd4;
        n_ard = {N_AW'(r1), N_AW'(r0)};
    endtask

    task automatic w_set(input bit we3, input int a3, input logic [63:0] wd3,
                         input bit we4, input int a4, input logic [63:0] wd4,
                         input int r0, input int r1, input int r2);
        w_we3 = we3; w_a3 = W_AW'(a3); w_wd3 = wd3;
        w_we4 = we4; w_a4 = W_AW'(a4); w_wd4 = wd4;
        w_ard = {W_AW'(r2), W_AW'(r1), W_AW'(r0)};
    endtask

    // Deassert RST and count edges until each BUSY falls (bounded).
    // When poke is set, port A tries to write entry 9 early in the clear.
    task automatic run_clear(input string tag, input bit poke);
        int n_fall;
        int w_fall;
        n_fall = 0;
        w_fall = 0;
        RST = 1'b0;
        for (int i = 1; i <= 150 && (n_fall == 0 || w_fall == 0); i++) begin
            n_set(poke && i <= 8, 9, 32'hA5A5_A5A5, 1'b0, 0, 32'd0, 9, 31);
            step();
            if (n_fall == 0 && !n_busy) n_fall = i;
            if (w_fall == 0 && !w_busy) w_fall = i;
        end
        n_set(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 9, 31);
        check({tag, "_n_clear_edges"}, 64'(n_fall), 64'd32);
        check({tag, "_w_clear_edges"}, 64'(w_fall), 64'd64);
    endtask

    function automatic int pick_n();
        return $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, N_DEPTH - 1));
    endfunction

    function automatic int pick_w();
        return $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, W_DEPTH - 1));
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        n_set(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 0, 0);
        w_set(1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 0, 0, 0);
        RST = 1'b1;
        repeat (3) step();

        // Clear after reset; a write attempted during the clear must not stick.
        run_clear("init", 1'b1);
        step();
        check("clr_write_dropped_a9", 64'(n_rd[31:0]), 64'd0);
        check("post_clear_a31", 64'(n_rd[63:32]), 64'd0);

        // Single write, same-cycle read and read after the edge.
        n_set(1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 32'd0, 5, 6);
        step();
        n_set(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 5, 6);
        step();
        check("a5_after_write", 64'(n_rd[31:0]), 64'hDEAD_BEEF);

        // Collision: both ports write entry 7, port B wins.
        n_set(1'b1, 7, 32'h1111_1111, 1'b1, 7, 32'h2222_2222, 7, 5);
        step();
        check("a7_port_b_wins", 64'(n_rd[31:0]), 64'h2222_2222);

        // Zero register: write to address 0 is dropped.
        n_set(1'b0, 0, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 0, 7);
        step();
        check("a0_stays_zero", 64'(n_rd[31:0]), 64'd0);
        n_set(1'b1, 0, 32'h1234_5678, 1'b0, 0, 32'd0, 0, 0);
        step();
        check("a0_still_zero", 64'(n_rd[63:32]), 64'd0);

        // Reset restarted mid-clear.
        n_set(1'b1, 3, 32'h0303_0303, 1'b1, 20, 32'h2020_2020, 3, 20);
        step();
        check("a3_written", 64'(n_rd[31:0]), 64'h0303_0303);
        check("a20_written", 64'(n_rd[63:32]), 64'h2020_2020);
        n_set(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 3, 20);
        RST = 1'b1; step();
        RST = 1'b0; repeat (10) step();
        RST = 1'b1; step();
        run_clear("restart", 1'b0);
        n_set(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, 3, 20);
        step();
        check("a3_cleared", 64'(n_rd[31:0]), 64'd0);
        check("a20_cleared", 64'(n_rd[63:32]), 64'd0);

        // Wide instance: three ports read 1, 33 and 63.
        w_set(1'b1, 1, 64'h0123_4567_89AB_CDEF, 1'b1, 33, 64'hFEDC_BA98_7654_3210, 1, 33, 63);
        step();
        w_set(1'b1, 63, 64'hCAFE_F00D_5555_AAAA, 1'b0, 0, 64'd0, 1, 33, 63);
        step();
        w_set(1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1, 33, 63);
        step();
        check("w_a1", w_rd[63:0], 64'h0123_4567_89AB_CDEF);
        check("w_a33", w_rd[127:64], 64'hFEDC_BA98_7654_3210);
        check("w_a63", w_rd[191:128], 64'hCAFE_F00D_5555_AAAA);

        // Randomized traffic on both instances; small address pool forces
        // collisions, address 0 and read-during-write cases.
        for (int k = 0; k < 300; k++) begin
            n_set(1'($urandom_range(0, 1)), pick_n(), $urandom,
                  1'($urandom_range(0, 1)), pick_n(), $urandom,
                  pick_n(), pick_n());
            w_set(1'($urandom_range(0, 1)), pick_w(), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), pick_w(), {$urandom, $urandom},
                  pick_w(), pick_w(), pick_w());
            step();
        end

        // Drain: idle write ports and read back a sweep of addresses.
        for (int k = 0; k < 16; k++) begin
            n_set(1'b0, 0, 32'd0, 1'b0, 0, 32'd0, k, k + 16);
            w_set(1'b0, 0, 64'd0, 1'b0, 0, 64'd0, k, k + 16, k + 48);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
